icache: RTL and testbench

- Direct-mapped, read-only instruction cache on the cache side of the datapath/cache interface.
- Answers the pipeline's fetch requests (imemREN/imemaddr) with ihit/imemload.
- Fills misses from the memory controller over the iREN/iaddr/iwait/iload instruction port.
- Sits between the datapath's fetch stage and memory_control; replaces the pass-through cache for instruction fetch.

---
 rtl/icache.sv | 114 +++++++++++
 tb/tb_icache.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: one-word frames, combinational
// hit path, single-beat fills from the memory controller's instruction port.
module icache #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        flush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   // state | meaning
   // IDLE  | serving hits from the array; a miss latches its address and starts a fill
   // FILL  | waiting on memory for the latched word; iREN high, ihit forced low

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   state_e            state_q;
   logic [31:0]       fill_addr_q;
   logic [31:0]       hit_cnt_q;
   logic [31:0]       miss_cnt_q;
   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [31:0]       data_q [SETS];

   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic              hit;
   logic              fill_done;
   logic [1:0]        unused_offset;

   assign req_idx       = imemaddr[IDX_W+1:2];
   assign req_tag       = imemaddr[31:IDX_W+2];
   assign fill_idx      = fill_addr_q[IDX_W+1:2];
   assign fill_tag      = fill_addr_q[31:IDX_W+2];
   assign unused_offset = imemaddr[1:0];

   assign hit       = imemREN && (state_q == IDLE) && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag);
   assign fill_done = (state_q == FILL) && !iwait;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         fill_addr_q <= '0;
         miss_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (imemREN && !hit && !flush) begin
                  fill_addr_q <= {imemaddr[31:2], 2'b00};
                  miss_cnt_q  <= miss_cnt_q + 32'd1;
                  state_q     <= FILL;
               end
            end
            FILL: begin
               if (!iwait) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_cnt_q <= '0;
      end else if (hit) begin
         hit_cnt_q <= hit_cnt_q + 32'd1;
      end
   end

   // flush takes priority so a fill completing on the flush edge stays invalid
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (fill_done) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (fill_done && nRST) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= iload;
      end
   end

   assign ihit       = hit;
   assign imemload   = hit ? data_q[req_idx] : 32'd0;
   assign iREN       = (state_q == FILL);
   assign iaddr      = (state_q == FILL) ? fill_addr_q : 32'd0;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (SETS=16): cold miss, repeat hits, conflict
// eviction, redirect during fill, flush corner cases and async reset mid-fill.
module tb_icache;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        flush;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int n_tests = 0;
   int n_fail  = 0;

   icache #(.SETS(16)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .flush      (flush),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Starts at a negedge in IDLE with addr uncached; returns at a negedge in IDLE
   // with imemREN dropped, so the confirming hit is not counted.
   task automatic miss_fill(input logic [31:0] addr, input logic [31:0] data, input int nwait);
      imemREN  = 1'b1;
      imemaddr = addr;
      iwait    = 1'b1;
      #1 chk("miss_ihit", {31'd0, ihit}, 32'd0);
      @(negedge CLK);
      #1 chk("fill_iren", {31'd0, iREN}, 32'd1);
      chk("fill_iaddr", iaddr, addr);
      chk("fill_ihit", {31'd0, ihit}, 32'd0);
      repeat (nwait - 1) @(negedge CLK);
      iwait = 1'b0;
      iload = data;
      @(negedge CLK);
      iwait = 1'b1;
      iload = 32'd0;
      #1 chk("after_fill_ihit", {31'd0, ihit}, 32'd1);
      chk("after_fill_data", imemload, data);
      imemREN = 1'b0;
   endtask

   initial begin
      nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'd0; flush = 1'b0;
      iwait = 1'b1; iload = 32'd0;
      repeat (2) @(negedge CLK);
      #1 chk("rst_ihit", {31'd0, ihit}, 32'd0);
      chk("rst_iren", {31'd0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_imemload", imemload, 32'd0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // cold miss
      miss_fill(32'h0000_0040, 32'h2001_0005, 3);
      chk("cold_misses", miss_count, 32'd1);
      chk("cold_hits", hit_count, 32'd0);

      // repeat hits
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      for (int i = 0; i < 5; i++) begin
         #1 chk("rep_ihit", {31'd0, ihit}, 32'd1);
         chk("rep_iren", {31'd0, iREN}, 32'd0);
         @(negedge CLK);
      end
      imemREN = 1'b0;
      #1 chk("rep_hits", hit_count, 32'd5);

      // conflict eviction on index 1
      miss_fill(32'h0000_0004, 32'h1111_1111, 1);
      miss_fill(32'h0000_0044, 32'h2222_2222, 2);
      chk("conf_misses", miss_count, 32'd3);
      miss_fill(32'h0000_0004, 32'h1111_1111, 1);
      chk("conf_misses2", miss_count, 32'd4);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0044;
      #1 chk("conf_evicted", {31'd0, ihit}, 32'd0);
      imemREN = 1'b0;
      @(negedge CLK);

      // redirect mid-fill (0x80 and 0x100 share index 0)
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0080;
      iwait    = 1'b1;
      #1 chk("rd_miss", {31'd0, ihit}, 32'd0);
      @(negedge CLK);
      imemaddr = 32'h0000_0100;
      #1 chk("rd_iaddr1", iaddr, 32'h80);
      chk("rd_ihit", {31'd0, ihit}, 32'd0);
      @(negedge CLK);
      #1 chk("rd_iaddr2", iaddr, 32'h80);
      iwait = 1'b0;
      iload = 32'hAAAA_0080;
      @(negedge CLK);
      iwait    = 1'b1;
      imemaddr = 32'h0000_0080;
      #1 chk("rd_80_hit", {31'd0, ihit}, 32'd1);
      chk("rd_80_data", imemload, 32'hAAAA_0080);
      imemaddr = 32'h0000_0100;
      #1 chk("rd_100_miss", {31'd0, ihit}, 32'd0);
      chk("rd_idle_iren", {31'd0, iREN}, 32'd0);
      @(negedge CLK);
      #1 chk("rd_iaddr3", iaddr, 32'h100);
      chk("rd_iren3", {31'd0, iREN}, 32'd1);
      iwait = 1'b0;
      iload = 32'hBBBB_0100;
      @(negedge CLK);
      iwait = 1'b1;
      #1 chk("rd_100_data", imemload, 32'hBBBB_0100);
      chk("rd_misses", miss_count, 32'd6);
      imemaddr = 32'h0000_0080;
      #1 chk("rd_80_evicted", {31'd0, ihit}, 32'd0);
      imemREN = 1'b0;
      @(negedge CLK);

      // flush with 0x40 (idx 0) and 0x88 (idx 2) valid
      miss_fill(32'h0000_0040, 32'h4040_0000, 1);
      miss_fill(32'h0000_0088, 32'h8888_0000, 1);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      flush    = 1'b1;
      #1 chk("fl_old_hit", {31'd0, ihit}, 32'd1);
      imemaddr = 32'h0000_000C;
      @(negedge CLK);
      flush   = 1'b0;
      imemREN = 1'b0;
      #1 chk("fl_no_fill", {31'd0, iREN}, 32'd0);
      chk("fl_misses", miss_count, 32'd8);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      #1 chk("fl_40_miss", {31'd0, ihit}, 32'd0);
      imemaddr = 32'h0000_0088;
      #1 chk("fl_88_miss", {31'd0, ihit}, 32'd0);
      imemREN = 1'b0;
      @(negedge CLK);

      // flush on the completing edge leaves the frame invalid
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      @(negedge CLK);
      imemREN = 1'b0;
      iwait   = 1'b0;
      iload   = 32'h5555_0040;
      flush   = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      iwait = 1'b1;
      #1 chk("flc_iren", {31'd0, iREN}, 32'd0);
      imemREN = 1'b1;
      #1 chk("flc_invalid", {31'd0, ihit}, 32'd0);
      @(negedge CLK);

      // flush earlier in the fill: the later completion still validates
      imemREN = 1'b0;
      flush   = 1'b1;
      #1 chk("fle_iren", {31'd0, iREN}, 32'd1);
      @(negedge CLK);
      flush = 1'b0;
      #1 chk("fle_still_fill", {31'd0, iREN}, 32'd1);
      iwait = 1'b0;
      iload = 32'h6666_0040;
      @(negedge CLK);
      iwait   = 1'b1;
      imemREN = 1'b1;
      #1 chk("fle_hit", {31'd0, ihit}, 32'd1);
      chk("fle_data", imemload, 32'h6666_0040);
      chk("fle_misses", miss_count, 32'd10);
      imemREN = 1'b0;
      chk("pre_rst_hits", hit_count, 32'd5);

      // async reset mid-fill
      miss_fill(32'h0000_000C, 32'hCCCC_000C, 1);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0010;
      @(negedge CLK);
      #1 chk("ar_iren_pre", {31'd0, iREN}, 32'd1);
      #1 nRST = 1'b0;
      #1 chk("ar_iren", {31'd0, iREN}, 32'd0);
      chk("ar_ihit", {31'd0, ihit}, 32'd0);
      chk("ar_iaddr", iaddr, 32'd0);
      chk("ar_hits", hit_count, 32'd0);
      chk("ar_misses", miss_count, 32'd0);
      imemREN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_000C;
      #1 chk("ar_0c_miss", {31'd0, ihit}, 32'd0);
      imemaddr = 32'h0000_0040;
      #1 chk("ar_40_miss", {31'd0, ihit}, 32'd0);
      imemaddr = 32'h0000_0010;
      #1 chk("ar_10_miss", {31'd0, ihit}, 32'd0);
      imemREN = 1'b0;
      @(negedge CLK);
      #1 chk("ar_idle", {31'd0, iREN}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
